fp8_e4m3_dot_mac: RTL and testbench

- Parametrised successor to the single-lane FP8 E4M3 MAC.
- Each accepted beat takes LANES pairs of E4M3 operands and adds their dot product into a wide fixed-point (Kulisch-style) accumulator, so accumulation is exact.
- On request, the accumulator is converted back to E4M3 with round-to-nearest-even and saturation.
- Sits as the compute element of the CNN convolution datapath, fed by the operand buffers.

---
 rtl/fp8_e4m3_dot_mac.sv | 210 +++++++++++++++++++++
 tb/tb_fp8_e4m3_dot_mac.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_e4m3_dot_mac.sv
// LANES-wide FP8 E4M3 dot-product MAC: exact fixed-point accumulation, RNE/saturating conversion back to E4M3.
// Define FP8_DOT_STATUS_EN to expose the sticky nan/sat flags as nan_flag/sat_flag ports.
module fp8_e4m3_dot_mac #(
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_a,
    input  logic [8*LANES-1:0] in_b,
    input  logic               clear_acc,
    input  logic               read_enable,
    output logic [7:0]         out_result,
    output logic               out_valid
`ifdef FP8_DOT_STATUS_EN
    ,
    output logic               nan_flag,
    output logic               sat_flag
`endif
);

    localparam int unsigned PROD_W       = 37;
    localparam int unsigned IDX_W        = $clog2(ACC_W);
    localparam int unsigned NORM_MIN_POS = 12;  // bit weight 2^-6 with 18 fraction bits
    localparam int unsigned SUB_LSB_POS  = 9;   // bit weight 2^-9, the subnormal LSB
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic is_nan(input logic [7:0] x);
        return x[6:0] == 7'h7F;
    endfunction

    // Exact signed product scaled to 18 fraction bits: sig_a*sig_b << (ea+eb-2)
    function automatic logic [PROD_W-1:0] lane_product(input logic [7:0] a, input logic [7:0] b);
        logic [3:0]        sig_a;
        logic [3:0]        sig_b;
        logic [4:0]        exp_a;
        logic [4:0]        exp_b;
        logic [PROD_W-1:0] mag;
        sig_a = {a[6:3] != 4'd0, a[2:0]};
        sig_b = {b[6:3] != 4'd0, b[2:0]};
        exp_a = (a[6:3] == 4'd0) ? 5'd1 : {1'b0, a[6:3]};
        exp_b = (b[6:3] == 4'd0) ? 5'd1 : {1'b0, b[6:3]};
        mag   = PROD_W'(8'(sig_a) * 8'(sig_b)) << (exp_a + exp_b - 5'd2);
        return (a[7] ^ b[7]) ? -mag : mag;
    endfunction

    logic               v0_q, v1_q, v2_q;
    logic [8*LANES-1:0] a0_q, b0_q;
    logic [PROD_W-1:0]  prod_q [LANES];
    logic [PROD_W-1:0]  prod_d [LANES];
    logic               nan1_q, nan1_d, nan2_q;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic               nan_q, nan_d, sat_q, sat_d;
    logic               rd_pend_q, rd_pend_d;
    logic               in_ready_q, out_valid_q;
    logic [7:0]         out_result_q, out_result_d;
    logic               accept, pipe_empty, fire;

    logic               conv_sign, found, guard, sticky;
    logic [ACC_W-1:0]   conv_mag;
    logic [IDX_W-1:0]   lead, sh;
    logic [2:0]         mant;
    logic [12:0]        e_code;
    logic [15:0]        code;
    logic [7:0]         conv;

    assign accept     = in_valid && in_ready_q;
    assign pipe_empty = !v0_q && !v1_q && !v2_q;
    assign fire       = rd_pend_q && pipe_empty;

    // S1: per-lane decode and multiply; NaN lanes contribute zero and raise the tag
    always_comb begin
        nan1_d = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i] = lane_product(a0_q[8*i +: 8], b0_q[8*i +: 8]);
            if (is_nan(a0_q[8*i +: 8]) || is_nan(b0_q[8*i +: 8])) begin
                prod_d[i] = '0;
                nan1_d    = 1'b1;
            end
        end
    end

    // S2: lane adder tree, sign-extended to accumulator width
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_d = sum_d + ACC_W'($signed(prod_q[i]));
        end
    end

    // ACC: clear wins; overflow saturates and freezes the accumulator until cleared
    always_comb begin
        acc_d   = acc_q;
        nan_d   = nan_q;
        sat_d   = sat_q;
        acc_sum = acc_q + sum_q;
        if (clear_acc) begin
            acc_d = '0;
            nan_d = 1'b0;
            sat_d = 1'b0;
        end else if (v2_q) begin
            nan_d = nan_q | nan2_q;
            if (!sat_q) begin
                if ((acc_q[ACC_W-1] == sum_q[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1])) begin
                    sat_d = 1'b1;
                    acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    // Accumulator to E4M3: leading-one normalise, RNE on guard/sticky, saturate at 448
    always_comb begin
        conv_sign = acc_q[ACC_W-1];
        conv_mag  = conv_sign ? -acc_q : acc_q;
        lead      = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            if (conv_mag[i]) begin
                lead  = IDX_W'(i);
                found = 1'b1;
            end
        end
        if (found && (lead >= IDX_W'(NORM_MIN_POS))) begin
            sh     = lead - IDX_W'(3);
            e_code = 13'(lead) - 13'd11;
        end else begin
            sh     = IDX_W'(SUB_LSB_POS);
            e_code = '0;
        end
        mant   = 3'(conv_mag >> sh);
        guard  = conv_mag[sh - IDX_W'(1)];
        sticky = |(conv_mag & ((ACC_W'(1) << (sh - IDX_W'(1))) - ACC_W'(1)));
        code   = {e_code, mant};
        if (guard && (sticky || mant[0])) begin
            code = code + 16'd1;
        end
        if (nan_q) begin
            conv = 8'h7F;
        end else if (sat_q || (code > 16'd126)) begin
            conv = {conv_sign, 7'h7E};
        end else if (code == 16'd0) begin
            conv = {conv_sign, 7'h00};
        end else begin
            conv = {conv_sign, code[6:0]};
        end
    end

    always_comb begin
        rd_pend_d    = rd_pend_q ? !pipe_empty : read_enable;
        out_result_d = fire ? conv : out_result_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            a0_q         <= '0;
            b0_q         <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            nan1_q       <= 1'b0;
            nan2_q       <= 1'b0;
            sum_q        <= '0;
            acc_q        <= '0;
            nan_q        <= 1'b0;
            sat_q        <= 1'b0;
            rd_pend_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 8'h00;
        end else begin
            v0_q <= accept;
            if (accept) begin
                a0_q <= in_a;
                b0_q <= in_b;
            end
            v1_q         <= v0_q && !clear_acc;
            prod_q       <= prod_d;
            nan1_q       <= nan1_d;
            v2_q         <= v1_q && !clear_acc;
            sum_q        <= sum_d;
            nan2_q       <= nan1_q;
            acc_q        <= acc_d;
            nan_q        <= nan_d;
            sat_q        <= sat_d;
            rd_pend_q    <= rd_pend_d;
            in_ready_q   <= !rd_pend_d;
            out_valid_q  <= fire;
            out_result_q <= out_result_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
`ifdef FP8_DOT_STATUS_EN
    assign nan_flag   = nan_q;
    assign sat_flag   = sat_q;
`endif

endmodule

// File: tb/tb_fp8_e4m3_dot_mac.sv
// Directed self-checking bench for fp8_e4m3_dot_mac (LANES=4, ACC_W=48); flag checks under FP8_DOT_STATUS_EN.
module tb_fp8_e4m3_dot_mac;

    localparam int unsigned LANES = 4;
    localparam int unsigned ACC_W = 48;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_a;
    logic [8*LANES-1:0] in_b;
    logic               clear_acc;
    logic               read_enable;
    logic [7:0]         out_result;
    logic               out_valid;
`ifdef FP8_DOT_STATUS_EN
    logic               nan_flag;
    logic               sat_flag;
`endif

    int checks = 0;
    int passed = 0;

    fp8_e4m3_dot_mac #(.LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .clear_acc   (clear_acc),
        .read_enable (read_enable),
        .out_result  (out_result),
        .out_valid   (out_valid)
`ifdef FP8_DOT_STATUS_EN
        ,
        .nan_flag    (nan_flag),
        .sat_flag    (sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        clear_acc   = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic do_clear();
        clear_acc = 1'b1;
        tick();
        clear_acc = 1'b0;
    endtask

    // Waits up to 20 edges after the request edge; lat = -1 if out_valid never pulsed
    task automatic wait_out(output logic [7:0] res, output int lat);
        res = 8'h00;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (lat < 0) begin
                tick();
                if (out_valid === 1'b1) begin
                    res = out_result;
                    lat = n;
                end
            end
        end
    endtask

    task automatic read_now(output logic [7:0] res, output int lat);
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        wait_out(res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        in_a = '0;
        in_b = '0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else passed++;
        checks++;
        if (out_result !== 8'h00) $display("FAIL reset_out_result: got %h expected 00", out_result);
        else passed++;
`ifdef FP8_DOT_STATUS_EN
        checks++;
        if ({nan_flag, sat_flag} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {nan_flag, sat_flag});
        else passed++;
`endif
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        else passed++;
    endtask

    // 4 x (1.0 * 2.0) = 8.0, read on the beat edge
    task automatic test_basic_dot();
        logic [7:0] res;
        int lat;
        set_beat(32'h38383838, 32'h40404040);
        read_enable = 1'b1;
        tick();
        idle();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL basic_ready_low: got %b expected 0", in_ready);
        else passed++;
        wait_out(res, lat);
        checks++;
        if (lat != 4) $display("FAIL basic_latency: got %0d expected 4", lat);
        else passed++;
        checks++;
        if (res !== 8'h50) $display("FAIL basic_result: got %h expected 50", res);
        else passed++;
    endtask

    // 1.0 + 0.0625 ties to even (1.0); a second 0.0625 gives 1.125
    task automatic test_rne_tie();
        logic [7:0] res;
        int lat;
        do_clear();
        set_beat(32'h00001838, 32'h00003838);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h38) $display("FAIL rne_tie_even: got %h expected 38", res);
        else passed++;
        set_beat(32'h00001800, 32'h00003800);
        tick();
        idle();
        repeat (4) tick();
        read_now(res, lat);
        checks++;
        if (lat != 1) $display("FAIL empty_pipe_latency: got %0d expected 1", lat);
        else passed++;
        checks++;
        if (res !== 8'h39) $display("FAIL rne_accumulate: got %h expected 39", res);
        else passed++;
    endtask

    // 4 x 448 = 1792 saturates the encoding only, not the accumulator
    task automatic test_range_saturate();
        logic [7:0] res;
        int lat;
        do_clear();
        set_beat(32'h7E7E7E7E, 32'h38383838);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h7E) $display("FAIL range_pos: got %h expected 7E", res);
        else passed++;
`ifdef FP8_DOT_STATUS_EN
        checks++;
        if (sat_flag !== 1'b0) $display("FAIL range_sat_flag: got %b expected 0", sat_flag);
        else passed++;
`endif
        do_clear();
        set_beat(32'h7E7E7E7E, 32'hB8B8B8B8);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'hFE) $display("FAIL range_neg: got %h expected FE", res);
        else passed++;
    endtask

    // 2^-9 is the smallest subnormal; -2^-10 is a tie that rounds to -0
    task automatic test_subnormal();
        logic [7:0] res;
        int lat;
        do_clear();
        set_beat(32'h00000001, 32'h00000038);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h01) $display("FAIL subnormal_min: got %h expected 01", res);
        else passed++;
        do_clear();
        set_beat(32'h00000081, 32'h00000030);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h80) $display("FAIL subnormal_neg_zero: got %h expected 80", res);
        else passed++;
    endtask

    task automatic test_nan_clear();
        logic [7:0] res;
        int lat;
        do_clear();
        set_beat(32'h387F3838, 32'h38383838);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h7F) $display("FAIL nan_result: got %h expected 7F", res);
        else passed++;
`ifdef FP8_DOT_STATUS_EN
        checks++;
        if (nan_flag !== 1'b1) $display("FAIL nan_flag_set: got %b expected 1", nan_flag);
        else passed++;
`endif
        clear_acc   = 1'b1;
        read_enable = 1'b1;
        tick();
        idle();
        wait_out(res, lat);
        checks++;
        if (res !== 8'h00) $display("FAIL clear_read_result: got %h expected 00", res);
        else passed++;
        checks++;
        if (lat != 1) $display("FAIL clear_read_latency: got %0d expected 1", lat);
        else passed++;
`ifdef FP8_DOT_STATUS_EN
        checks++;
        if (nan_flag !== 1'b0) $display("FAIL nan_flag_cleared: got %b expected 0", nan_flag);
        else passed++;
`endif
    endtask

    // Two 4.0 beats in flight are flushed; the 2.0 beat on the clear edge survives
    task automatic test_clear_same_edge();
        logic [7:0] res;
        int lat;
        set_beat(32'h38383838, 32'h38383838);
        tick();
        set_beat(32'h38383838, 32'h38383838);
        tick();
        set_beat(32'h00000040, 32'h00000038);
        clear_acc = 1'b1;
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h40) $display("FAIL clear_same_edge: got %h expected 40", res);
        else passed++;
    endtask

    // in_valid held high while the read is pending: nothing else may be accepted
    task automatic test_read_same_edge();
        logic [7:0] res;
        int lat;
        int ready_high;
        do_clear();
        set_beat(32'h00000038, 32'h00000038);
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        set_beat(32'h00000040, 32'h00000038);
        lat = -1;
        res = 8'h00;
        ready_high = 0;
        for (int n = 1; n <= 20; n++) begin
            if (lat < 0) begin
                tick();
                if (out_valid === 1'b1) begin
                    res = out_result;
                    lat = n;
                    in_valid = 1'b0;
                end else if (in_ready !== 1'b0) begin
                    ready_high++;
                end
            end
        end
        idle();
        checks++;
        if (lat != 4) $display("FAIL read_same_latency: got %0d expected 4", lat);
        else passed++;
        checks++;
        if (res !== 8'h38) $display("FAIL read_same_result: got %h expected 38", res);
        else passed++;
        checks++;
        if (ready_high != 0) $display("FAIL read_pending_ready: got %0d high cycles expected 0", ready_high);
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_read: got %b expected 1", in_ready);
        else passed++;
    endtask

    // Three consecutive 4.0 beats sum to 12.0
    task automatic test_back_to_back();
        logic [7:0] res;
        int lat;
        int ready_low;
        do_clear();
        ready_low = 0;
        set_beat(32'h38383838, 32'h38383838);
        repeat (3) begin
            if (in_ready !== 1'b1) ready_low++;
            tick();
        end
        idle();
        checks++;
        if (ready_low != 0) $display("FAIL b2b_ready: got %0d stalls expected 0", ready_low);
        else passed++;
        read_now(res, lat);
        checks++;
        if (res !== 8'h54) $display("FAIL b2b_result: got %h expected 54", res);
        else passed++;
    endtask

    // 700 beats of 4*196*2^28 exceed 2^47; a later negative beat must not move the held max
    task automatic test_overflow_sat();
        logic [7:0] res;
        int lat;
        do_clear();
        set_beat(32'h7E7E7E7E, 32'h7E7E7E7E);
        repeat (700) tick();
        set_beat(32'h7E7E7E7E, 32'hFEFEFEFE);
        tick();
        idle();
        read_now(res, lat);
        checks++;
        if (res !== 8'h7E) $display("FAIL overflow_sat_result: got %h expected 7E", res);
        else passed++;
`ifdef FP8_DOT_STATUS_EN
        checks++;
        if (sat_flag !== 1'b1) $display("FAIL overflow_sat_flag: got %b expected 1", sat_flag);
        else passed++;
`endif
        do_clear();
        read_now(res, lat);
        checks++;
        if (res !== 8'h00) $display("FAIL overflow_cleared: got %h expected 00", res);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] res;
        int lat;
        int ov_seen;
        do_clear();
        set_beat(32'h38383838, 32'h38383838);
        read_enable = 1'b1;
        tick();
        idle();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b expected 0", in_ready);
        else passed++;
        rst = 1'b1;
        ov_seen = 0;
        repeat (8) begin
            tick();
            if (out_valid !== 1'b0) ov_seen++;
        end
        checks++;
        if (ov_seen != 0) $display("FAIL mid_reset_no_out: got %0d pulses expected 0", ov_seen);
        else passed++;
        read_now(res, lat);
        checks++;
        if (res !== 8'h00) $display("FAIL mid_reset_read: got %h expected 00", res);
        else passed++;
        checks++;
        if (lat != 1) $display("FAIL mid_reset_latency: got %0d expected 1", lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_dot();
        test_rne_tie();
        test_range_saturate();
        test_subnormal();
        test_nan_clear();
        test_clear_same_edge();
        test_read_same_edge();
        test_back_to_back();
        test_overflow_sat();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
